// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch, decode, execute,
// memory and writeback and drives the datapath selects and enables.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zeroflag,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    alu_sel    = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    state      = state_q;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_sel   = ALU_ADD;
        pc_en     = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // branch target precomputed into ALUOut
        alu_src_b = 2'b11;
        alu_sel   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_RTYPE:       state_d = R_EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          OP_ADDI:        state_d = ADDI_EX;
          default:        illegal_op = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = ALU_ADD;
        state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = R_WB;
        case (funct)
          6'h20:   alu_sel = ALU_ADD;
          6'h22:   alu_sel = ALU_SUB;
          6'h24:   alu_sel = ALU_AND;
          6'h25:   alu_sel = ALU_OR;
          6'h2A:   alu_sel = ALU_SLT;
          default: begin
            alu_sel    = ALU_ADD;
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        // IR is not rewritten here, so opcode still names the branch
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = (opcode == OP_BNE) ? ~zeroflag : zeroflag;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = ALU_ADD;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    if (rst) begin
      state_d    = FETCH;
      alu_sel    = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      state      = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction cycle tables
// checked every cycle, directed cases plus random instruction streams.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zeroflag = 1'b0;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zeroflag(zeroflag), .alu_sel(alu_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [20:0] dut_vec;
  assign dut_vec = {alu_sel, alu_src_a, alu_src_b, pc_src, pc_en, iord,
                    mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, illegal_op, state};

  // model state: current instruction and cycle index within it
  logic [5:0] cur_op, cur_fn;
  int k = 0;
  bit have = 0;
  logic [5:0] fq_op[$];
  logic [5:0] fq_fn[$];

  function automatic logic [20:0] pk(int st, int sel, int sa, int sb,
      int ps, int pe, int io, int mr, int mw, int iw, int rd, int m2,
      int rw, int il);
    return {sel[2:0], sa[0], sb[1:0], ps[1:0], pe[0], io[0], mr[0],
            mw[0], iw[0], rd[0], m2[0], rw[0], il[0], st[3:0]};
  endfunction

  function automatic bit legal_op(logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  function automatic int fn_sel(logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int ilen(logic [5:0] op, logic [5:0] fn);
    if (!legal_op(op)) return 2;
    case (op)
      6'h23: return 5;
      6'h2B, 6'h08: return 4;
      6'h00: return (fn_sel(fn) < 0) ? 3 : 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [20:0] expect_vec(logic [5:0] op,
      logic [5:0] fn, int kk, logic zf);
    int s;
    if (kk == 0) return pk(0, 2, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    if (kk == 1)
      return pk(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                legal_op(op) ? 0 : 1);
    case (op)
      6'h23, 6'h2B: begin
        if (kk == 2) return pk(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (op == 6'h2B)
          return pk(5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        if (kk == 3) return pk(3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        return pk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      end
      6'h00: begin
        s = fn_sel(fn);
        if (kk == 2)
          return pk(6, (s < 0) ? 2 : s, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    (s < 0) ? 1 : 0);
        return pk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      end
      6'h04, 6'h05:
        return pk(8, 6, 1, 0, 1, (op == 6'h04) ? int'(zf) : int'(!zf),
                  0, 0, 0, 0, 0, 0, 0, 0);
      6'h02: return pk(9, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      default: begin
        if (kk == 2) return pk(10, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        return pk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      end
    endcase
  endfunction

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pick();
    int c;
    if (fq_op.size() > 0) begin
      cur_op = fq_op.pop_front();
      cur_fn = fq_fn.pop_front();
    end else begin
      c = $urandom_range(0, 8);
      case (c)
        0, 8: cur_op = 6'h00;
        1: cur_op = 6'h23;
        2: cur_op = 6'h2B;
        3: cur_op = 6'h04;
        4: cur_op = 6'h05;
        5: cur_op = 6'h08;
        6: cur_op = 6'h02;
        default: begin
          cur_op = 6'($urandom_range(0, 63));
          while (legal_op(cur_op)) cur_op = 6'($urandom_range(0, 63));
        end
      endcase
      case ($urandom_range(0, 5))
        0: cur_fn = 6'h20;
        1: cur_fn = 6'h22;
        2: cur_fn = 6'h24;
        3: cur_fn = 6'h25;
        4: cur_fn = 6'h2A;
        default: cur_fn = 6'($urandom_range(0, 63));
      endcase
    end
    have = 1;
  endtask

  task automatic drive_check(logic r, logic z);
    logic [20:0] exp;
    @(negedge clk);
    rst = r;
    zeroflag = z;
    if (!r && !have) pick();
    opcode = cur_op;
    funct = cur_fn;
    #1;
    exp = r ? 21'd0 : expect_vec(cur_op, cur_fn, k, z);
    n_checks++;
    if (dut_vec !== exp) begin
      n_fail++;
      $display("FAIL cycle op=%h fn=%h k=%0d rst=%b: got %h expected %h",
               cur_op, cur_fn, k, r, dut_vec, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      k = 0;
      have = 0;
    end else begin
      k++;
      if (k == ilen(cur_op, cur_fn)) begin
        k = 0;
        have = 0;
      end
    end
  endtask

  task automatic step(logic r, logic z);
    drive_check(r, z);
    advance();
  endtask

  task automatic force_op(logic [5:0] op, logic [5:0] fn);
    fq_op.push_back(op);
    fq_fn.push_back(fn);
  endtask

  initial begin
    cur_op = 6'h00;
    cur_fn = 6'h20;
    for (int i = 0; i < 2; i++) begin
      drive_check(1'b1, 1'b0);
      lit("reset_zero", 32'(dut_vec), 32'd0);
      advance();
    end

    force_op(6'h23, 6'h00);
    for (int i = 0; i < 5; i++) begin
      drive_check(1'b0, 1'b0);
      lit("lw_state", 32'(state), 32'(i));
      if (i == 0)
        lit("fetch_outs", {alu_sel, mem_read, ir_write, pc_en},
            {3'b010, 3'b111});
      lit("lw_wb", {reg_write, mem_to_reg}, (i == 4) ? 2'b11 : 2'b00);
      advance();
    end

    force_op(6'h00, 6'h22);
    force_op(6'h00, 6'h2A);
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++) begin
        drive_check(1'b0, 1'b0);
        if (i == 2)
          lit("r_alu_sel", 32'(alu_sel), (n == 0) ? 32'd6 : 32'd7);
        if (i == 3)
          lit("r_wb", {state, reg_write, reg_dst}, {4'd7, 2'b11});
        advance();
      end

    force_op(6'h04, 6'h00);
    force_op(6'h04, 6'h00);
    force_op(6'h05, 6'h00);
    force_op(6'h05, 6'h00);
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 3; i++) begin
        drive_check(1'b0, (i == 2) ? logic'(n % 2 == 0) : 1'b0);
        if (i == 2)
          lit("branch_pc", {state, pc_src, pc_en},
              {4'd8, 2'b01, logic'(n == 0 || n == 3)});
        advance();
      end

    force_op(6'h3F, 6'h20);
    drive_check(1'b0, 1'b0);
    advance();
    drive_check(1'b0, 1'b0);
    lit("illegal_op_decode", {illegal_op, reg_write, mem_write}, 3'b100);
    advance();
    force_op(6'h00, 6'h3F);
    drive_check(1'b0, 1'b0);
    lit("after_illegal_state", 32'(state), 32'd0);
    advance();
    step(1'b0, 1'b0);
    drive_check(1'b0, 1'b0);
    lit("illegal_funct", {state, illegal_op}, {4'd6, 1'b1});
    advance();
    drive_check(1'b0, 1'b0);
    lit("no_r_wb", 32'(state), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    force_op(6'h2B, 6'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    drive_check(1'b1, 1'b0);
    lit("rst_mem_wr", 32'(mem_write), 32'd0);
    advance();
    drive_check(1'b0, 1'b0);
    lit("rst_to_fetch", 32'(state), 32'd0);
    advance();

    for (int i = 0; i < 3000; i++)
      step(logic'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
